// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state codes, owner codes and grant type for the memory port arbiter
package mem_port_arbiter_pkg;

    // Sequencer states: wait for a request, drive the memory, return the response
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Which requester currently owns the memory port
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_F    = 2'd1,
        OWNER_D    = 2'd2
    } owner_t;

    // One-hot grant from the selector; at most one bit is ever set
    typedef struct packed {
        logic f;
        logic d;
    } grant_t;

    // Translate a grant into the owner code that is latched on a grant
    function automatic owner_t grant_owner(input grant_t g);
        if (g.f) return OWNER_F;
        if (g.d) return OWNER_D;
        return OWNER_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// rtl/mem_port_arbiter_pick.sv - priority plus starvation selector between fetch and data
module mem_port_arbiter_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic             f_elig,
    input  logic             d_elig,
    input  logic [CNT_W-1:0] starve_cnt,
    output grant_t           grant
);

    logic starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Data wins by default; fetch wins when alone or once it has waited STARVE_MAX data grants
    always_comb begin
        grant = '0;
        if (f_elig && (!d_elig || starved)) begin
            grant.f = 1'b1;
        end else if (d_elig) begin
            grant.d = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serializes fetch and data load/store onto one synchronous memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 65536,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // One extra bit so that MEM_WORDS == 2**ADDR_W accepts every address
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < MEM_LIMIT);
    endfunction

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;
    logic             arb_slot;
    logic             f_elig;
    logic             d_elig;
    grant_t           grant;

    // Grants are only made while the port is free or finishing; the requester
    // being acked this cycle is masked so it cannot be granted twice.
    assign arb_slot = (state == ARB_IDLE) || (state == ARB_RESP);
    assign f_elig   = arb_slot && f_req && !((state == ARB_RESP) && (owner == OWNER_F));
    assign d_elig   = arb_slot && d_req && !((state == ARB_RESP) && (owner == OWNER_D));

    mem_port_arbiter_pick #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .f_elig     (f_elig),
        .d_elig     (d_elig),
        .starve_cnt (starve_cnt),
        .grant      (grant)
    );

    // Starvation count to apply if a grant is made this cycle
    always_comb begin
        starve_next = starve_cnt;
        if (grant.f || !f_elig) begin
            starve_next = '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_next = starve_cnt + CNT_W'(1);
        end
    end

    // Read data is only routed to the requester being acked; the other side reads zero
    assign f_rdata = f_ack ? mem_rdata : '0;
    assign d_rdata = d_ack ? mem_rdata : '0;

    // Sequencer: grant and drive the memory, then ack the owner one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_NONE;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            f_ack      <= 1'b0;
            f_err      <= 1'b0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            f_ack  <= 1'b0;
            f_err  <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ARB_ISSUE: begin
                    // mem_addr still holds the granted address, so it qualifies the error
                    state <= ARB_RESP;
                    f_ack <= (owner == OWNER_F);
                    d_ack <= (owner == OWNER_D);
                    f_err <= (owner == OWNER_F) && !addr_ok(mem_addr);
                    d_err <= (owner == OWNER_D) && !addr_ok(mem_addr);
                end
                ARB_IDLE, ARB_RESP: begin
                    if (grant.f || grant.d) begin
                        state      <= ARB_ISSUE;
                        owner      <= grant_owner(grant);
                        mem_addr   <= grant.f ? f_addr : d_addr;
                        starve_cnt <= starve_next;
                        if (grant.d) begin
                            mem_wdata <= d_wdata;
                        end
                        mem_we <= grant.d && d_we && addr_ok(d_addr);
                    end else begin
                        state <= ARB_IDLE;
                        owner <= OWNER_NONE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    owner <= OWNER_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level model
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int MEM_WORDS  = 1024;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous memory: read data one cycle after the address; preload port for setup
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: one access in flight, grant allowed unless one was made last cycle,
    // ack two cycles after grant, write happens in the cycle after grant.
    logic [DATA_W-1:0] model_mem [0:DEPTH-1] = '{default: '0};
    int cyc = 0, last_grant = -100, p_owner = 0, p_ack = -1, p_we = -1, m_starve = 0;
    logic              p_err = 1'b0, p_load = 1'b0;
    logic [DATA_W-1:0] p_rdata = '0, p_wdata = '0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic e_f_ack, e_d_ack, e_f_err, e_d_err, e_mem_we, e_issue, e_f_rd, e_d_rd;
    int checks = 0, errors = 0;

    task automatic tick();
        bit ack_f, ack_d, ef, ed, gf, gd, inr;
        ack_f = (p_ack == cyc) && (p_owner == 1);
        ack_d = (p_ack == cyc) && (p_owner == 2);
        if (reset) begin
            m_starve = 0; last_grant = -100; p_owner = 0; p_ack = -1; p_we = -1;
        end else if (cyc - last_grant >= 2) begin
            ef = f_req && !ack_f;
            ed = d_req && !ack_d;
            gf = ef && (!ed || m_starve == STARVE_MAX);
            gd = ed && !gf;
            if (gf || gd) begin
                last_grant = cyc;
                p_ack = cyc + 2;
                if (gf) begin
                    p_owner = 1; p_addr = f_addr; p_load = 1'b1; m_starve = 0;
                end else begin
                    p_owner = 2; p_addr = d_addr; p_load = !d_we; p_wdata = d_wdata;
                    m_starve = ef ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                end
                inr = (int'(p_addr) < MEM_WORDS);
                p_err = !inr;
                p_rdata = model_mem[p_addr];
                p_we = (gd && d_we && inr) ? cyc + 1 : -1;
                if (gd && d_we && inr) model_mem[p_addr] = d_wdata;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        e_f_ack  = (p_ack == cyc) && (p_owner == 1);
        e_d_ack  = (p_ack == cyc) && (p_owner == 2);
        e_f_err  = e_f_ack && p_err;
        e_d_err  = e_d_ack && p_err;
        e_mem_we = (p_we == cyc);
        e_issue  = (p_ack == cyc + 1);
        e_f_rd   = e_f_ack && !p_err;
        e_d_rd   = e_d_ack && !p_err && p_load;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        model_mem[a] = v;
        tick();
        pl_en = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return ADDR_W'($urandom_range(MEM_WORDS, DEPTH - 1));
        return ADDR_W'($urandom_range(0, 63));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({f_ack, d_ack, f_err, d_err, mem_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl: got %b want 00000", {f_ack, d_ack, f_err, d_err, mem_we});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_mem: got addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        end
        checks++;
        if (dut.state !== ARB_IDLE || dut.starve_cnt !== '0) begin
            errors++; $display("FAIL reset_state: got %0d cnt %0d want IDLE 0", dut.state, dut.starve_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        preload(16'h0010, 32'hDEADBEEF);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        tick();
        checks++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0 || d_ack !== 1'b0) begin
            errors++; $display("FAIL load_issue: got addr %h we %b ack %b want 0010 0 0", mem_addr, mem_we, d_ack);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF || f_ack !== 1'b0 || d_err !== 1'b0) begin
            errors++; $display("FAIL load_resp: got ack %b data %h f_ack %b err %b want 1 deadbeef 0 0", d_ack, d_rdata, f_ack, d_err);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (d_ack !== 1'b0 || d_rdata !== '0) begin
            errors++; $display("FAIL load_after: got ack %b data %h want 0 0", d_ack, d_rdata);
        end
    endtask

    task automatic test_store_fetch();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'h12345678;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 32'h12345678) begin
            errors++; $display("FAIL store_issue: got we %b addr %h wdata %h want 1 0020 12345678", mem_we, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL store_resp: got ack %b err %b we %b want 1 0 0", d_ack, d_err, mem_we);
        end
        // Fetch presented in the store's ack cycle is granted back-to-back
        d_req = 1'b0; d_we = 1'b0; f_req = 1'b1; f_addr = 16'h0020;
        tick();
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0020) begin
            errors++; $display("FAIL fetch_issue: got we %b addr %h want 0 0020", mem_we, mem_addr);
        end
        tick();
        checks++;
        if (f_ack !== 1'b1 || f_rdata !== 32'h12345678 || f_err !== 1'b0 || d_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_resp: got ack %b data %h err %b d_ack %b want 1 12345678 0 0", f_ack, f_rdata, f_err, d_ack);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        int d_at, f_at;
        d_at = -1; f_at = -1;
        f_req = 1'b1; f_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (d_ack && d_at < 0) begin d_at = k; d_req = 1'b0; end
            if (f_ack && f_at < 0) begin
                f_at = k; f_req = 1'b0;
                checks++;
                if (f_rdata !== 32'h12345678) begin
                    errors++; $display("FAIL simul_fdata: got %h want 12345678", f_rdata);
                end
            end
        end
        checks++;
        if (d_at != 2 || f_at != 4) begin
            errors++; $display("FAIL simul_order: got d_ack@%0d f_ack@%0d want 2 4", d_at, f_at);
        end
    endtask

    task automatic test_starvation();
        int dacks, facks, f_at, d_at;
        dacks = 0; facks = 0;
        // Fetch competes at each data grant but withdraws before being served
        for (int r = 0; r < STARVE_MAX; r++) begin
            f_req = 1'b1; f_addr = 16'h0010; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
            tick();
            f_req = 1'b0;
            tick();
            dacks += int'(d_ack); facks += int'(f_ack);
            d_req = 1'b0;
            tick();
        end
        checks++;
        if (dacks != STARVE_MAX || facks != 0 || int'(dut.starve_cnt) != STARVE_MAX) begin
            errors++; $display("FAIL starve_build: got dacks %0d facks %0d cnt %0d want %0d 0 %0d", dacks, facks, dut.starve_cnt, STARVE_MAX, STARVE_MAX);
        end
        f_at = -1; d_at = -1;
        f_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (f_ack && f_at < 0) begin f_at = k; f_req = 1'b0; end
            if (d_ack && d_at < 0) begin d_at = k; d_req = 1'b0; end
        end
        checks++;
        if (f_at != 2 || d_at != 4) begin
            errors++; $display("FAIL starve_win: got f_ack@%0d d_ack@%0d want 2 4", f_at, d_at);
        end
        checks++;
        if (dut.starve_cnt !== '0) begin
            errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_out_of_range();
        int we_seen, bad;
        we_seen = 0; bad = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 32'hA5A5A5A5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            we_seen += int'(mem_we);
            if (k == 2) begin
                checks++;
                if (d_ack !== 1'b1 || d_err !== 1'b1) begin
                    errors++; $display("FAIL oor_store: got ack %b err %b want 1 1", d_ack, d_err);
                end
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        checks++;
        if (we_seen != 0) begin
            errors++; $display("FAIL oor_we: got %0d write cycles want 0", we_seen);
        end
        for (int a = 0; a < MEM_WORDS; a++) if (mem[a] !== model_mem[a]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL oor_mem: got %0d changed words want 0", bad);
        end
        f_req = 1'b1; f_addr = 16'hFFFF;
        tick();
        tick();
        checks++;
        if (f_ack !== 1'b1 || f_err !== 1'b1 || d_err !== 1'b0) begin
            errors++; $display("FAIL oor_fetch: got ack %b err %b d_err %b want 1 1 0", f_ack, f_err, d_err);
        end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        f_req = 1'b1; f_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        tick();
        checks++;
        if (int'(dut.starve_cnt) != 1 || mem_addr !== 16'h0010) begin
            errors++; $display("FAIL rst_pre: got cnt %0d addr %h want 1 0010", dut.starve_cnt, mem_addr);
        end
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
        tick();
        checks++;
        if (d_ack !== 1'b0 || f_ack !== 1'b0 || mem_we !== 1'b0 || dut.state !== ARB_IDLE || dut.starve_cnt !== '0) begin
            errors++; $display("FAIL rst_mid: got d_ack %b f_ack %b we %b state %0d cnt %0d want 0 0 0 IDLE 0", d_ack, f_ack, mem_we, dut.state, dut.starve_cnt);
        end
        reset = 1'b0;
        d_req = 1'b1;
        tick();
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rst_reload: got ack %b data %h want 1 deadbeef", d_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit f_seen, d_seen;
        f_seen = 0; d_seen = 0;
        for (int i = 0; i < 800; i++) begin
            if (f_req && f_seen) begin
                f_req = 1'($urandom_range(0, 1));
                f_addr = rnd_addr();
            end else if (!f_req && $urandom_range(0, 9) < 4) begin
                f_req = 1'b1; f_addr = rnd_addr();
            end
            if (d_req && d_seen) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 9) < 5) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
            end
            tick();
            checks++;
            if ({f_ack, d_ack, f_err, d_err, mem_we} !== {e_f_ack, e_d_ack, e_f_err, e_d_err, e_mem_we}) begin
                errors++; $display("FAIL rnd_ctl cyc %0d: got %b want %b", cyc, {f_ack, d_ack, f_err, d_err, mem_we}, {e_f_ack, e_d_ack, e_f_err, e_d_err, e_mem_we});
            end
            if (e_issue) begin
                checks++;
                if (mem_addr !== p_addr || (e_mem_we && mem_wdata !== p_wdata)) begin
                    errors++; $display("FAIL rnd_issue cyc %0d: got addr %h wdata %h want %h %h", cyc, mem_addr, mem_wdata, p_addr, p_wdata);
                end
            end
            if (e_f_rd || !e_f_ack) begin
                checks++;
                if (f_rdata !== (e_f_rd ? p_rdata : '0)) begin
                    errors++; $display("FAIL rnd_frdata cyc %0d: got %h want %h", cyc, f_rdata, e_f_rd ? p_rdata : '0);
                end
            end
            if (e_d_rd || !e_d_ack) begin
                checks++;
                if (d_rdata !== (e_d_rd ? p_rdata : '0)) begin
                    errors++; $display("FAIL rnd_drdata cyc %0d: got %h want %h", cyc, d_rdata, e_d_rd ? p_rdata : '0);
                end
            end
            checks++;
            if (int'(dut.starve_cnt) != m_starve) begin
                errors++; $display("FAIL rnd_starve cyc %0d: got %0d want %0d", cyc, dut.starve_cnt, m_starve);
            end
            f_seen = e_f_ack;
            d_seen = e_d_ack;
        end
        f_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_load();
        test_store_fetch();
        test_simultaneous();
        test_starvation();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
